decim2_fifo: RTL and testbench

Decimate-by-2 stage directly downstream of the half-band filter (`half_band_filter_2`). It accepts one 18-bit signed sample per qualified clock and discards the filter's pipeline-fill samples after reset. It keeps every second sample and buffers the kept samples in a small FIFO. A valid/ready handshake hands them to the next consumer, and a sticky flag reports overflow.

---
 rtl/decim2_fifo.sv | 124 ++++++++++++
 tb/tb_decim2_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/decim2_fifo.sv
//------------------------------------------------------------------------------
// decim2_fifo : discards filter warm-up samples, keeps every second sample,
//               and buffers the kept ones in a FIFO with a valid/ready output.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module decim2_fifo #(
  parameter int DEPTH  = 8,
  parameter int WARMUP = 9,
  parameter int PHASE  = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [17:0]                x_in,
  input  logic                       in_valid,
  output logic [17:0]                y,
  output logic                       y_valid,
  input  logic                       y_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  localparam logic [LW-1:0] C_DEPTH  = LW'(DEPTH);
  localparam logic [CW-1:0] C_WARMUP = CW'(WARMUP);
  localparam logic          C_PHASE  = (PHASE != 0);

  logic [17:0]   mem_q [DEPTH];
  logic [CW-1:0] warm_q,    warm_d;
  logic          phase_q,   phase_d;
  logic [AW-1:0] wr_ptr_q,  wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,  rd_ptr_d;
  logic [LW-1:0] level_q,   level_d;
  logic [17:0]   y_q,       y_d;
  logic          y_valid_q, y_valid_d;
  logic          ovf_q,     ovf_d;

  logic pop;
  logic warm_done;
  logic keep;
  logic full;
  logic push;

  assign pop       = y_valid_q & y_ready;
  assign warm_done = (warm_q == C_WARMUP);
  assign keep      = in_valid & warm_done & (phase_q == C_PHASE);
  assign full      = (level_q == C_DEPTH);
  assign push      = keep & (~full | pop);

  always_comb begin
    warm_d    = warm_q;
    phase_d   = phase_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    y_d       = y_q;
    ovf_d     = ovf_q;

    if (in_valid) begin
      if (!warm_done) warm_d  = warm_q + CW'(1);
      else            phase_d = ~phase_q;
    end

    if (keep && !push) ovf_d = 1'b1;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // The head register is refilled from the next slot, or straight from the
    // input when the FIFO would otherwise have nothing older to show.
    if (pop) begin
      if (level_q > LW'(1)) y_d = mem_q[rd_ptr_q + AW'(1)];
      else if (push)        y_d = x_in;
    end else if (level_q == '0 && push) begin
      y_d = x_in;
    end

    y_valid_d = (level_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      warm_q    <= '0;
      phase_q   <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      warm_q    <= warm_d;
      phase_q   <= phase_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= x_in;
  end

  assign y        = y_q;
  assign y_valid  = y_valid_q;
  assign level    = level_q;
  assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_decim2_fifo.sv
//------------------------------------------------------------------------------
// tb_decim2_fifo : checks decim2_fifo (PHASE 0 and PHASE 1 instances) against
//                  constant vectors and a queue-based reference model.
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_decim2_fifo;

  localparam int DEPTH  = 8;
  localparam int WARMUP = 9;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] x_in;
  logic        in_valid;
  logic        y_ready;

  logic [17:0] y0, y1;
  logic        yv0, yv1;
  logic [3:0]  lvl0, lvl1;
  logic        ovf0, ovf1;

  int errors   = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  decim2_fifo #(.DEPTH(DEPTH), .WARMUP(WARMUP), .PHASE(0)) dut0 (
    .clk(clk), .reset(reset), .x_in(x_in), .in_valid(in_valid),
    .y(y0), .y_valid(yv0), .y_ready(y_ready), .level(lvl0), .overflow(ovf0)
  );

  decim2_fifo #(.DEPTH(DEPTH), .WARMUP(WARMUP), .PHASE(1)) dut1 (
    .clk(clk), .reset(reset), .x_in(x_in), .in_valid(in_valid),
    .y(y1), .y_valid(yv1), .y_ready(y_ready), .level(lvl1), .overflow(ovf1)
  );

  // Reference model for the PHASE=0 instance: sample count, kept-sample queue.
  logic [17:0] mq[$];
  int          mn;
  bit          movf;
  logic [17:0] mlast;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic v, input logic [17:0] x,
                            input logic rdy);
    bit mpop, mkeep;
    int sz;
    if (r) begin
      mq.delete();
      mn    = 0;
      movf  = 0;
      mlast = '0;
    end else begin
      sz    = mq.size();
      mpop  = (sz != 0) && rdy;
      mkeep = v && (mn >= WARMUP) && (((mn - WARMUP) % 2) == 0);
      if (v) mn++;
      if (mpop) void'(mq.pop_front());
      if (mkeep) begin
        if (sz < DEPTH || mpop) mq.push_back(x);
        else                    movf = 1;
      end
      if (mq.size() != 0) mlast = mq[0];
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [17:0] x,
                     input logic rdy);
    reset    = r;
    in_valid = v;
    x_in     = x;
    y_ready  = rdy;
    @(posedge clk);
    model_edge(r, v, x, rdy);
    #1;
    chk("model y_valid",  int'(yv0),  int'(mq.size() != 0));
    chk("model level",    int'(lvl0), mq.size());
    chk("model overflow", int'(ovf0), int'(movf));
    chk("model y",        int'(y0),   int'(mlast));
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0);
  endtask

  typedef struct {
    logic        v;
    logic [17:0] x;
    logic        rdy;
    logic        ev0;
    logic [17:0] ey0;
    logic        ev1;
    logic [17:0] ey1;
  } vec_t;

  vec_t        tbl [24];
  logic [17:0] drain_exp [10];
  logic [17:0] got[$];

  initial begin
    // Ungapped full-rate stream x = 1..24; PHASE 0 keeps evens from 10,
    // PHASE 1 keeps odds from 11; y holds the last kept value in between.
    for (int k = 1; k <= 24; k++) begin
      tbl[k-1].v   = 1'b1;
      tbl[k-1].x   = 18'(k);
      tbl[k-1].rdy = 1'b1;
      tbl[k-1].ev0 = (k >= 10) && (k % 2 == 0);
      tbl[k-1].ey0 = (k < 10) ? 18'd0 : 18'(k - (k % 2));
      tbl[k-1].ev1 = (k >= 11) && (k % 2 == 1);
      tbl[k-1].ey1 = (k < 11) ? 18'd0 : 18'((k % 2 == 1) ? k : k - 1);
    end
    drain_exp = '{18'd10, 18'd12, 18'd14, 18'd16, 18'd18,
                  18'd20, 18'd22, 18'd24, 18'd28, 18'd30};

    reset = 1'b1; in_valid = 1'b0; x_in = '0; y_ready = 1'b0;

    // Reset state
    do_reset();
    chk("reset y_valid",  int'(yv0),  0);
    chk("reset level",    int'(lvl0), 0);
    chk("reset overflow", int'(ovf0), 0);
    chk("reset y",        int'(y0),   0);

    // Warm-up and decimation, both phases
    for (int i = 0; i < 24; i++) begin
      cyc(1'b0, tbl[i].v, tbl[i].x, tbl[i].rdy);
      chk($sformatf("tbl[%0d] y_valid0", i), int'(yv0), int'(tbl[i].ev0));
      chk($sformatf("tbl[%0d] y0", i),       int'(y0),  int'(tbl[i].ey0));
      chk($sformatf("tbl[%0d] y_valid1", i), int'(yv1), int'(tbl[i].ev1));
      chk($sformatf("tbl[%0d] y1", i),       int'(y1),  int'(tbl[i].ey1));
    end

    // Gapped input: only valid cycles advance warm-up and phase
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b0, 1'b1, 18'(k), 1'b1);
      if (k == 9)  chk("gap warmup y_valid0", int'(yv0), 0);
      if (k == 10) chk("gap first y0", int'(y0), 10);
      if (k == 11) chk("gap first y1", int'(y1), 11);
      if (k == 14) chk("gap y0 14", int'(y0), 14);
      cyc(1'b0, 1'b0, 18'h3FFFF, 1'b1);
    end

    // Backpressure, overflow, then drain order
    do_reset();
    for (int k = 1; k <= 26; k++) begin
      cyc(1'b0, 1'b1, 18'(k), 1'b0);
      if (k == 25) begin
        chk("bp level full", int'(lvl0), 8);
        chk("bp no overflow yet", int'(ovf0), 0);
      end
    end
    chk("bp overflow set", int'(ovf0), 1);
    chk("bp y held", int'(y0), 10);
    chk("bp level sat", int'(lvl0), 8);
    got.delete();
    for (int k = 27; k <= 38; k++) begin
      if (yv0) got.push_back(y0);
      cyc(1'b0, 1'b1, 18'(k), 1'b1);
    end
    chk("bp drain count", (got.size() >= 10) ? 1 : 0, 1);
    for (int i = 0; i < 10 && i < got.size(); i++)
      chk($sformatf("bp drain[%0d]", i), int'(got[i]), int'(drain_exp[i]));
    chk("bp overflow sticky", int'(ovf0), 1);

    // Full FIFO with pop on the same cycle a kept sample arrives
    do_reset();
    for (int k = 1; k <= 25; k++) cyc(1'b0, 1'b1, 18'(k), 1'b0);
    chk("fullpop pre level", int'(lvl0), 8);
    cyc(1'b0, 1'b1, 18'd26, 1'b1);
    chk("fullpop level", int'(lvl0), 8);
    chk("fullpop overflow", int'(ovf0), 0);
    chk("fullpop y", int'(y0), 12);

    // Signed extremes pass bit-exact
    do_reset();
    for (int k = 1; k <= 9; k++) cyc(1'b0, 1'b1, 18'd0, 1'b1);
    cyc(1'b0, 1'b1, 18'h20000, 1'b1);
    chk("extreme neg", int'(y0), int'(18'h20000));
    cyc(1'b0, 1'b1, 18'd0, 1'b1);
    cyc(1'b0, 1'b1, 18'h1FFFF, 1'b1);
    chk("extreme pos", int'(y0), int'(18'h1FFFF));

    // Reset mid-stream with level 5 and overflow set
    do_reset();
    for (int k = 1; k <= 26; k++) cyc(1'b0, 1'b1, 18'(k), 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 1'b1);
    chk("mid level 5", int'(lvl0), 5);
    chk("mid overflow 1", int'(ovf0), 1);
    cyc(1'b1, 1'b0, '0, 1'b0);
    chk("mid rst y_valid", int'(yv0), 0);
    chk("mid rst level", int'(lvl0), 0);
    chk("mid rst overflow", int'(ovf0), 0);
    chk("mid rst y", int'(y0), 0);
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b0, 1'b1, 18'(k + 100), 1'b1);
      if (k == 9) chk("mid rewarm y_valid", int'(yv0), 0);
    end
    chk("mid resume y", int'(y0), 110);

    // Randomized traffic with occasional resets, alternating ready bias
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic r, v, rdy;
      r   = ($urandom_range(0, 299) == 0);
      v   = ($urandom_range(0, 3) != 0);
      rdy = (((i / 300) % 2) == 0) ? ($urandom_range(0, 3) != 0)
                                   : ($urandom_range(0, 3) == 0);
      cyc(r, v, 18'($urandom), rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
